// File: rtl/wb_arbiter.sv
// Writeback sequencer: three one-entry holding registers (ALU, load, jump) drained
// round-robin into a single registered register-file write port, with speculative parking.
module wb_arbiter #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,

  input  logic              alu_valid,
  input  logic              alu_spec,
  input  logic [WORD_W-1:0] alu_wdat,
  input  logic [REG_W-1:0]  alu_reg_sel,
  output logic              alu_ready,

  input  logic              load_valid,
  input  logic              load_spec,
  input  logic [WORD_W-1:0] load_wdat,
  input  logic [REG_W-1:0]  load_reg_sel,
  output logic              load_ready,

  input  logic              jump_valid,
  input  logic              jump_spec,
  input  logic [WORD_W-1:0] jump_wdat,
  input  logic [REG_W-1:0]  jump_reg_sel,
  output logic              jump_ready,

  input  logic              branch_correct,
  input  logic              branch_mispredict,

  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_wsel,
  output logic [WORD_W-1:0] rf_wdat,
  output logic              wb_busy
);

  localparam int unsigned N_SRC = 3;
  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_JUMP = IDX_W'(2);

  // Source-indexed views of the per-unit ports (ALU=0, LOAD=1, JUMP=2)
  logic [N_SRC-1:0]  in_valid;
  logic [N_SRC-1:0]  in_spec;
  logic [REG_W-1:0]  in_sel [N_SRC];
  logic [WORD_W-1:0] in_dat [N_SRC];

  assign in_valid  = {jump_valid, load_valid, alu_valid};
  assign in_spec   = {jump_spec, load_spec, alu_spec};
  assign in_sel[0] = alu_reg_sel;
  assign in_sel[1] = load_reg_sel;
  assign in_sel[2] = jump_reg_sel;
  assign in_dat[0] = alu_wdat;
  assign in_dat[1] = load_wdat;
  assign in_dat[2] = jump_wdat;

  // Holding-register state
  logic [N_SRC-1:0]  full_q, full_d;
  logic [N_SRC-1:0]  spec_q, spec_d;
  logic [REG_W-1:0]  sel_q  [N_SRC];
  logic [REG_W-1:0]  sel_d  [N_SRC];
  logic [WORD_W-1:0] dat_q  [N_SRC];
  logic [WORD_W-1:0] dat_d  [N_SRC];
  logic [IDX_W-1:0]  last_q;

  // Arbitration signals
  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  grant;
  logic [N_SRC-1:0]  ready;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  cand;
  logic              gnt_any;

  assign elig = full_q & ~spec_q;

  // Round-robin search beginning one past the last granted source
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    grant   = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((32'(last_q) + 32'(k)) % 32'(N_SRC));
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // A granted entry frees its slot this cycle, so refill can overlap the drain
  assign ready = ~full_q | grant;

  assign alu_ready  = ready[0];
  assign load_ready = ready[1];
  assign jump_ready = ready[2];
  assign wb_busy    = |full_q;

  // Holding-register next state: drain, capture, then branch resolution
  always_comb begin
    full_d = full_q & ~grant;
    spec_d = spec_q;
    sel_d  = sel_q;
    dat_d  = dat_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (in_valid[i] && ready[i]) begin
        full_d[i] = 1'b1;
        spec_d[i] = in_spec[i];
        sel_d[i]  = in_sel[i];
        dat_d[i]  = in_dat[i];
      end
    end
    // Mispredict takes priority and also drops a spec entry captured this edge
    if (branch_mispredict) begin
      full_d = full_d & ~spec_d;
      spec_d = '0;
    end else if (branch_correct) begin
      spec_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full_q <= '0;
      spec_q <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        sel_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      spec_q <= spec_d;
      sel_q  <= sel_d;
      dat_q  <= dat_d;
    end
  end

  // Registered write port; reg 0 consumes the entry without a write strobe
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q  <= IDX_JUMP;
      rf_wen  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else if (gnt_any) begin
      last_q  <= gnt_idx;
      rf_wen  <= |sel_q[gnt_idx];
      rf_wsel <= sel_q[gnt_idx];
      rf_wdat <= dat_q[gnt_idx];
    end else begin
      rf_wen  <= 1'b0;
    end
  end

endmodule
